// File: rtl/ex_div_pkg.sv
// ex_div_pkg: shared state encodings, constants and helpers for the execute-stage divider
package ex_div_pkg;
   typedef enum logic [1:0] {
      DIV_FREE    = 2'b00,
      DIV_BY_ZERO = 2'b01,
      DIV_ON      = 2'b10,
      DIV_END     = 2'b11
   } div_state_e;
   localparam logic       DIV_RESULT_READY     = 1'b1;
   localparam logic       DIV_RESULT_NOT_READY = 1'b0;
   localparam logic [5:0] DIV_ITERS            = 6'd32;
   // magnitude of a two's-complement value, or the value untouched for unsigned operation
   function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
      return (en && v[31]) ? (~v + 32'd1) : v;
   endfunction
endpackage

// File: rtl/ex_div.sv
// ex_div: multi-cycle restoring 32-bit divider (DIV/DIVU) for the execute stage
module ex_div
   import ex_div_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);
   div_state_e  r_state, w_next;
   logic [5:0]  r_cnt;
   logic [64:0] r_work;
   logic [31:0] r_divisor;
   logic        r_sign1, r_sign2, r_signed;
   logic [63:0] r_result;
   logic        r_ready;
   logic [64:0] w_shift;
   logic [32:0] w_diff;
   logic [31:0] w_quot, w_rem;
   logic        w_last;
   // working register is {remainder[32:0], quotient/dividend[31:0]}; the 33-bit
   // trial difference has its MSB set exactly when the partial remainder is below the divisor
   assign w_shift  = r_work << 1;
   assign w_diff   = w_shift[64:32] - {1'b0, r_divisor};
   assign w_last   = r_cnt == DIV_ITERS;
   assign w_quot   = (r_signed && (r_sign1 ^ r_sign2)) ? (~r_work[31:0] + 32'd1) : r_work[31:0];
   assign w_rem    = (r_signed && r_sign1) ? (~r_work[63:32] + 32'd1) : r_work[63:32];
   assign result_o = r_result;
   assign ready_o  = r_ready;
   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= DIV_FREE;
      else      r_state <= w_next;
   end
   // next state; a flush aborts from any state
   always_comb begin
      w_next = r_state;
      if (annul_i) w_next = DIV_FREE;
      else begin
         case (r_state)
            DIV_FREE:    if (start_i) w_next = (opdata2_i == 32'd0) ? DIV_BY_ZERO : DIV_ON;
            DIV_BY_ZERO: w_next = DIV_END;
            DIV_ON:      if (w_last) w_next = DIV_END;
            DIV_END:     if (!start_i) w_next = DIV_FREE;
            default:     w_next = DIV_FREE;
         endcase
      end
   end
   // operand capture, restoring iterations, sign correction and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt     <= '0;
         r_work    <= '0;
         r_divisor <= '0;
         r_sign1   <= 1'b0;
         r_sign2   <= 1'b0;
         r_signed  <= 1'b0;
         r_result  <= '0;
         r_ready   <= DIV_RESULT_NOT_READY;
      end else begin
         r_ready <= (r_state == DIV_END && start_i && !annul_i) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
         if (r_state == DIV_FREE && w_next == DIV_ON) begin
            r_cnt     <= '0;
            r_work    <= {33'd0, abs32(opdata1_i, signed_div_i)};
            r_divisor <= abs32(opdata2_i, signed_div_i);
            r_sign1   <= opdata1_i[31];
            r_sign2   <= opdata2_i[31];
            r_signed  <= signed_div_i;
         end else if (r_state == DIV_ON && !annul_i && !w_last) begin
            r_work <= w_diff[32] ? w_shift : {w_diff, w_shift[31:0] | 32'd1};
            r_cnt  <= r_cnt + 6'd1;
         end
         if (r_state == DIV_ON && w_last && !annul_i) r_result <= {w_rem, w_quot};
         else if (w_next == DIV_FREE || r_state == DIV_BY_ZERO) r_result <= '0;
      end
   end
endmodule
